udp_tx_sched: RTL

//  Transmit-side scheduler for the UDP/ARP Ethernet path. Collects ARP-reply requests from the

---
 rtl/udp_tx_sched_pkg.sv | 27 ++
 rtl/udp_tx_sched_pulse_sync.sv | 30 +++
 rtl/udp_tx_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/udp_tx_sched_pkg.sv
// Shared types and default parameters for the UDP/ARP transmit scheduler.
package udp_tx_sched_pkg;

  // Default frame and timing parameters
  localparam int unsigned UDP_BYTES_DEF = 1024;  // payload bytes per UDP frame
  localparam int unsigned LVL_W_DEF     = 12;    // width of the FIFO nibble-level input
  localparam int unsigned IFG_CYC_DEF   = 24;    // 96 bit times at 4 bits per t_clk
  localparam int unsigned WD_CYC_DEF    = 4096;  // framer watchdog limit in t_clk cycles
  localparam int unsigned ERR_W         = 8;     // width of the saturating abort counter

  // Scheduler states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } sched_state_t;

  // Grant selection: round-robin on contention, otherwise whichever source is pending.
  // Returns 1 for an ARP grant and 0 for a UDP grant.
  function automatic logic rr_pick_arp(input logic arp_pend,
                                       input logic udp_rdy,
                                       input logic last_arp);
    return (arp_pend & udp_rdy) ? ~last_arp : arp_pend;
  endfunction

endpackage

// File: rtl/udp_tx_sched_pulse_sync.sv
// Two-flop synchroniser with a third flop for edge detection. Produces a
// one-cycle pulse in the destination clock domain for each rising edge of
// the asynchronous input.
module pulse_sync (
  input  logic clk_i,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic sync3_q;

  // Synchronise the level, then keep one older sample to find its rising edge
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/udp_tx_sched.sv
// Transmit-side scheduler: arbitrates the single nibble-wide tx framer between
// ARP replies and UDP payload frames, enforces the inter-frame gap and aborts
// a frame whose framer never reports completion.
module udp_tx_sched
  import udp_tx_sched_pkg::*;
#(
  parameter int unsigned UDP_BYTES = UDP_BYTES_DEF,
  parameter int unsigned LVL_W     = LVL_W_DEF,
  parameter int unsigned IFG_CYC   = IFG_CYC_DEF,
  parameter int unsigned WD_CYC    = WD_CYC_DEF
) (
  input  logic             t_clk,
  input  logic             rst_n,
  input  logic             arp_req,
  input  logic             udp_en,
  input  logic [LVL_W-1:0] udp_level,
  input  logic             tx_done,
  output logic             tx_start,
  output logic             tx_arp,
  output logic             tx_abort,
  output logic             sched_busy,
  output logic [ERR_W-1:0] wd_err_cnt
);

  localparam int unsigned WD_W  = (WD_CYC  > 1) ? $clog2(WD_CYC)  : 1;
  localparam int unsigned GAP_W = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;

  // FIFO must hold a full frame's worth of nibbles before UDP may be granted
  localparam logic [LVL_W-1:0] UDP_THRESH = LVL_W'(2 * UDP_BYTES);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(WD_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(IFG_CYC - 1);

  sched_state_t     state_q;
  logic             arp_pend_q;
  logic             arp_pend_d;
  logic             last_arp_q;
  logic             tx_start_q;
  logic             tx_arp_q;
  logic             tx_abort_q;
  logic             busy_q;
  logic [WD_W-1:0]  wd_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [ERR_W-1:0] err_q;

  logic arp_rise;
  logic udp_rdy;
  logic grant_valid;
  logic grant_arp;

  pulse_sync u_arp_sync (
    .clk_i   (t_clk),
    .rst_n   (rst_n),
    .async_i (arp_req),
    .rise_o  (arp_rise)
  );

  assign udp_rdy     = udp_en & (udp_level >= UDP_THRESH);
  assign grant_valid = (state_q == S_IDLE) & (arp_pend_q | udp_rdy);
  assign grant_arp   = rr_pick_arp(arp_pend_q, udp_rdy, last_arp_q);

  // Pending ARP request: a new edge wins over the clear so a request that
  // lands exactly on an ARP grant is kept for the next frame.
  always_comb begin
    arp_pend_d = arp_pend_q;
    if (grant_valid && grant_arp) begin
      arp_pend_d = 1'b0;
    end
    if (arp_rise) begin
      arp_pend_d = 1'b1;
    end
  end

  // Register the pending-ARP flag
  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      arp_pend_q <= 1'b0;
    end else begin
      arp_pend_q <= arp_pend_d;
    end
  end

  // Scheduler FSM with registered outputs, watchdog and gap counters
  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_arp_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_arp_q   <= 1'b0;
      tx_abort_q <= 1'b0;
      busy_q     <= 1'b0;
      wd_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      err_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      tx_abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_valid) begin
            state_q    <= S_START;
            tx_start_q <= 1'b1;
            tx_arp_q   <= grant_arp;
            busy_q     <= 1'b1;
          end
        end
        S_START: begin
          wd_cnt_q <= '0;
          state_q  <= S_BUSY;
        end
        S_BUSY: begin
          wd_cnt_q <= wd_cnt_q + 1'b1;
          // Completion takes priority over a watchdog expiry in the same cycle
          if (tx_done) begin
            last_arp_q <= tx_arp_q;
            gap_cnt_q  <= '0;
            state_q    <= S_GAP;
          end else if (wd_cnt_q == WD_LAST) begin
            tx_abort_q <= 1'b1;
            if (err_q != '1) begin
              err_q <= err_q + 1'b1;
            end
            gap_cnt_q <= '0;
            state_q   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_arp     = tx_arp_q;
  assign tx_abort   = tx_abort_q;
  assign sched_busy = busy_q;
  assign wd_err_cnt = err_q;

endmodule
